// File: rtl/msrh_rnid_freelist_pkg.sv
// Shared configuration and types for the rnid free list: sizes, rnid type and the
// per-group commit rename update.
package msrh_rnid_freelist_pkg;

  localparam int unsigned DISP_SIZE = 4;
  localparam int unsigned RNID_SIZE = 64;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned FREE_SIZE = RNID_SIZE - ARCH_REGS;
  localparam int unsigned RNID_W    = $clog2(RNID_SIZE);
  localparam int unsigned PTR_W     = $clog2(FREE_SIZE);
  localparam int unsigned CNT_W     = $clog2(FREE_SIZE + 1);
  localparam int unsigned OFF_W     = $clog2(DISP_SIZE + 1);
  localparam int unsigned REGIDX_W  = 5;

  typedef logic [RNID_W-1:0] rnid_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic                                commit;
    logic [DISP_SIZE-1:0]                rnid_valid;
    logic [DISP_SIZE-1:0][RNID_W-1:0]    old_rnid;
    logic [DISP_SIZE-1:0][RNID_W-1:0]    rd_rnid;
    logic [DISP_SIZE-1:0][REGIDX_W-1:0]  rd_regidx;
    logic [DISP_SIZE-1:0]                dead_id;
    logic                                all_dead;
  } cmt_rnid_upd_t;

  // Wrap by compare so that non-power-of-two depths work; inc never exceeds FREE_SIZE.
  function automatic ptr_t ptr_wrap_add(ptr_t ptr, logic [OFF_W-1:0] inc);
    logic [PTR_W:0] sum;
    sum = (PTR_W+1)'(ptr) + (PTR_W+1)'(inc);
    if (sum >= (PTR_W+1)'(FREE_SIZE)) begin
      sum = sum - (PTR_W+1)'(FREE_SIZE);
    end
    return sum[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/msrh_rnid_compact.sv
// Prefix-count of a slot valid mask: each slot gets the number of valid slots below it.
module msrh_rnid_compact
  import msrh_rnid_freelist_pkg::*;
(
  input  logic [DISP_SIZE-1:0]            i_valid,
  output logic [DISP_SIZE-1:0][OFF_W-1:0] o_offset,
  output logic [OFF_W-1:0]                o_total
);

  always_comb begin : p_scan
    logic [OFF_W-1:0] acc;
    acc      = '0;
    o_offset = '0;
    for (int d = 0; d < DISP_SIZE; d++) begin
      o_offset[d] = acc;
      acc         = acc + OFF_W'(i_valid[d]);
    end
    o_total = acc;
  end

endmodule

// File: rtl/msrh_rnid_freelist.sv
// Physical-register free list: multi-pop to rename, multi-push of rnids recycled at commit,
// as a compacting circular FIFO with a sticky overflow flag.
module msrh_rnid_freelist
  import msrh_rnid_freelist_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_alloc_valid,
  input  logic [DISP_SIZE-1:0]             i_alloc_mask,
  output logic                             o_alloc_ready,
  output logic [DISP_SIZE-1:0][RNID_W-1:0] o_alloc_rnid,
  input  cmt_rnid_upd_t                    i_cmt_rnid_upd,
  output logic [CNT_W-1:0]                 o_free_count,
  output logic                             o_overflow_err
);

  rnid_t r_entry [FREE_SIZE];
  ptr_t  r_head;
  ptr_t  r_tail;
  cnt_t  r_count;
  logic  r_overflow_err;

  logic [DISP_SIZE-1:0][OFF_W-1:0] w_pop_off;
  logic [OFF_W-1:0]                w_pop_total;
  logic                            w_pop_fire;
  logic [OFF_W-1:0]                w_pop_cnt;

  logic [DISP_SIZE-1:0]             w_push_qual;
  logic [DISP_SIZE-1:0][RNID_W-1:0] w_push_val;
  logic [DISP_SIZE-1:0][OFF_W-1:0]  w_push_off;
  logic [OFF_W-1:0]                 w_push_total;
  logic [DISP_SIZE-1:0]             w_push_ok;
  ptr_t                             w_push_idx [DISP_SIZE];
  cnt_t                             w_remain;
  cnt_t                             w_space;
  logic                             w_overflow;
  logic [OFF_W-1:0]                 w_push_acc;

  msrh_rnid_compact u_pop_compact (
    .i_valid  (i_alloc_mask),
    .o_offset (w_pop_off),
    .o_total  (w_pop_total)
  );

  // Ready uses only the registered count: rnids freed this cycle are not yet allocatable.
  assign o_alloc_ready = (r_count >= CNT_W'(w_pop_total));
  assign w_pop_fire    = i_alloc_valid & o_alloc_ready;
  assign w_pop_cnt     = w_pop_fire ? w_pop_total : '0;

  always_comb begin
    o_alloc_rnid = '0;
    for (int d = 0; d < DISP_SIZE; d++) begin
      if (i_alloc_mask[d]) begin
        o_alloc_rnid[d] = r_entry[ptr_wrap_add(r_head, w_pop_off[d])];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < DISP_SIZE; d++) begin
      w_push_qual[d] = i_cmt_rnid_upd.commit & i_cmt_rnid_upd.rnid_valid[d] &
                       (i_cmt_rnid_upd.rd_regidx[d] != '0);
      w_push_val[d]  = (i_cmt_rnid_upd.all_dead | i_cmt_rnid_upd.dead_id[d]) ?
                       i_cmt_rnid_upd.rd_rnid[d] : i_cmt_rnid_upd.old_rnid[d];
    end
  end

  msrh_rnid_compact u_push_compact (
    .i_valid  (w_push_qual),
    .o_offset (w_push_off),
    .o_total  (w_push_total)
  );

  // Space left after this cycle's pops; pushes beyond it are dropped.
  assign w_remain   = r_count - CNT_W'(w_pop_cnt);
  assign w_space    = CNT_W'(FREE_SIZE) - w_remain;
  assign w_overflow = (CNT_W'(w_push_total) > w_space);
  assign w_push_acc = w_overflow ? OFF_W'(w_space) : w_push_total;

  always_comb begin
    for (int d = 0; d < DISP_SIZE; d++) begin
      w_push_ok[d]  = w_push_qual[d] & (CNT_W'(w_push_off[d]) < w_space);
      w_push_idx[d] = ptr_wrap_add(r_tail, w_push_off[d]);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < FREE_SIZE; i++) begin
        r_entry[i] <= RNID_W'(ARCH_REGS + i);
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= CNT_W'(FREE_SIZE);
      r_overflow_err <= 1'b0;
    end else begin
      for (int d = 0; d < DISP_SIZE; d++) begin
        if (w_push_ok[d]) begin
          r_entry[w_push_idx[d]] <= w_push_val[d];
        end
      end
      r_head  <= ptr_wrap_add(r_head, w_pop_cnt);
      r_tail  <= ptr_wrap_add(r_tail, w_push_acc);
      r_count <= w_remain + CNT_W'(w_push_acc);
      if (w_overflow) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

  assign o_free_count   = r_count;
  assign o_overflow_err = r_overflow_err;

`ifdef SIMULATION
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (!w_overflow) else $warning("rnid freelist overflow: excess pushes dropped");
    end
  end
`endif

endmodule

// File: tb/tb_msrh_rnid_freelist.sv
// Directed self-checking bench for the rnid free list.
module tb_msrh_rnid_freelist;
  import msrh_rnid_freelist_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alloc_valid;
  logic [3:0]       alloc_mask;
  logic             alloc_ready;
  logic [3:0][5:0]  alloc_rnid;
  cmt_rnid_upd_t    upd;
  logic [5:0]       free_count;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msrh_rnid_freelist u_dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_alloc_valid  (alloc_valid),
    .i_alloc_mask   (alloc_mask),
    .o_alloc_ready  (alloc_ready),
    .o_alloc_rnid   (alloc_rnid),
    .i_cmt_rnid_upd (upd),
    .o_free_count   (free_count),
    .o_overflow_err (ovf)
  );

  // Advance one clock and return inputs to idle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    alloc_mask  = '0;
    upd         = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_mask = '0; upd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++; if (free_count !== 6'd32) begin n_fail++;
      $display("FAIL reset_count: got %0d expected 32", free_count); end
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %0b expected 1", alloc_ready); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++;
      $display("FAIL reset_ovf: got %0b expected 0", ovf); end
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (alloc_rnid[d] !== 6'd0) begin n_fail++;
        $display("FAIL reset_rnid slot %0d: got %0d expected 0", d, alloc_rnid[d]); end
    end
  endtask

  task automatic test_alloc();
    int exp0 [4];
    exp0 = '{32, 33, 0, 34};
    alloc_valid = 1'b1; alloc_mask = 4'b1011;
    #1;
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++;
      $display("FAIL alloc_ready: got %0b expected 1", alloc_ready); end
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (alloc_rnid[d] !== 6'(exp0[d])) begin n_fail++;
        $display("FAIL alloc_1011 slot %0d: got %0d expected %0d", d, alloc_rnid[d], exp0[d]);
      end
    end
    tick();
    n_checks++; if (free_count !== 6'd29) begin n_fail++;
      $display("FAIL alloc_count: got %0d expected 29", free_count); end
    // Two full-width pops: 35..38 then 39..42.
    for (int i = 0; i < 2; i++) begin
      alloc_valid = 1'b1; alloc_mask = 4'b1111;
      #1;
      for (int d = 0; d < 4; d++) begin
        n_checks++; if (alloc_rnid[d] !== 6'(35 + 4 * i + d)) begin n_fail++;
          $display("FAIL alloc_full%0d slot %0d: got %0d expected %0d", i, d, alloc_rnid[d],
                   35 + 4 * i + d);
        end
      end
      tick();
    end
    n_checks++; if (free_count !== 6'd21) begin n_fail++;
      $display("FAIL alloc_full_count: got %0d expected 21", free_count); end
  endtask

  task automatic test_push();
    // Live commit: old rnids 40,41 -> entries 0,1.
    upd.commit = 1'b1; upd.rnid_valid = 4'b0011;
    upd.old_rnid[0] = 6'd40; upd.old_rnid[1] = 6'd41;
    upd.rd_regidx[0] = 5'd3; upd.rd_regidx[1] = 5'd4;
    tick();
    n_checks++; if (free_count !== 6'd23) begin n_fail++;
      $display("FAIL push_live_count: got %0d expected 23", free_count); end
    // Mixed dead: pushes 10,11,52,53 -> entries 2..5.
    upd.commit = 1'b1; upd.rnid_valid = 4'b1111; upd.dead_id = 4'b1100;
    for (int d = 0; d < 4; d++) begin
      upd.rd_rnid[d] = 6'(50 + d); upd.old_rnid[d] = 6'(10 + d); upd.rd_regidx[d] = 5'(d + 1);
    end
    tick();
    n_checks++; if (free_count !== 6'd27) begin n_fail++;
      $display("FAIL push_dead_count: got %0d expected 27", free_count); end
    // All dead, sparse valid: pushes 45,47 -> entries 6,7.
    upd.commit = 1'b1; upd.all_dead = 1'b1; upd.rnid_valid = 4'b0101;
    upd.rd_rnid[0] = 6'd45; upd.rd_rnid[1] = 6'd46; upd.rd_rnid[2] = 6'd47;
    upd.old_rnid[0] = 6'd1; upd.old_rnid[2] = 6'd2;
    upd.rd_regidx[0] = 5'd7; upd.rd_regidx[2] = 5'd8;
    tick();
    n_checks++; if (free_count !== 6'd29) begin n_fail++;
      $display("FAIL push_alldead_count: got %0d expected 29", free_count); end
    // Slot 0 targets x0 and is skipped: only 20 -> entry 8.
    upd.commit = 1'b1; upd.rnid_valid = 4'b0011;
    upd.old_rnid[0] = 6'd7; upd.rd_regidx[0] = 5'd0;
    upd.old_rnid[1] = 6'd20; upd.rd_regidx[1] = 5'd5;
    tick();
    n_checks++; if (free_count !== 6'd30) begin n_fail++;
      $display("FAIL push_x0_count: got %0d expected 30", free_count); end
  endtask

  task automatic test_drain_wrap();
    int exp1 [4];
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_mask = 4'b1111;
      #1;
      for (int d = 0; d < 4; d++) begin
        n_checks++; if (alloc_rnid[d] !== 6'(43 + 4 * i + d)) begin n_fail++;
          $display("FAIL drain%0d slot %0d: got %0d expected %0d", i, d, alloc_rnid[d],
                   43 + 4 * i + d);
        end
      end
      tick();
    end
    n_checks++; if (free_count !== 6'd10) begin n_fail++;
      $display("FAIL drain_count: got %0d expected 10", free_count); end
    // head = 31: entries 31 and 0.
    alloc_valid = 1'b1; alloc_mask = 4'b0011;
    #1;
    n_checks++; if (alloc_rnid[0] !== 6'd63) begin n_fail++;
      $display("FAIL wrap slot 0: got %0d expected 63", alloc_rnid[0]); end
    n_checks++; if (alloc_rnid[1] !== 6'd40) begin n_fail++;
      $display("FAIL wrap slot 1: got %0d expected 40", alloc_rnid[1]); end
    tick();
    exp1 = '{41, 10, 11, 52};
    alloc_valid = 1'b1; alloc_mask = 4'b1111;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (alloc_rnid[d] !== 6'(exp1[d])) begin n_fail++;
        $display("FAIL after_wrap slot %0d: got %0d expected %0d", d, alloc_rnid[d], exp1[d]);
      end
    end
    tick();
    alloc_valid = 1'b1; alloc_mask = 4'b0011;
    #1;
    n_checks++; if (alloc_rnid[0] !== 6'd53 || alloc_rnid[1] !== 6'd45) begin n_fail++;
      $display("FAIL pop_53_45: got %0d,%0d expected 53,45", alloc_rnid[0], alloc_rnid[1]); end
    tick();
    n_checks++; if (free_count !== 6'd2) begin n_fail++;
      $display("FAIL drain2_count: got %0d expected 2", free_count); end
  endtask

  task automatic test_stall();
    int exp2 [4];
    alloc_valid = 1'b1; alloc_mask = 4'b0111;
    upd.commit = 1'b1; upd.rnid_valid = 4'b0011;
    upd.old_rnid[0] = 6'd21; upd.old_rnid[1] = 6'd22;
    upd.rd_regidx[0] = 5'd1; upd.rd_regidx[1] = 5'd2;
    #1;
    n_checks++; if (alloc_ready !== 1'b0) begin n_fail++;
      $display("FAIL stall_ready: got %0b expected 0", alloc_ready); end
    tick();
    n_checks++; if (free_count !== 6'd4) begin n_fail++;
      $display("FAIL stall_count: got %0d expected 4", free_count); end
    exp2 = '{47, 20, 21, 22};
    alloc_valid = 1'b1; alloc_mask = 4'b1111;
    #1;
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++;
      $display("FAIL unstall_ready: got %0b expected 1", alloc_ready); end
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (alloc_rnid[d] !== 6'(exp2[d])) begin n_fail++;
        $display("FAIL unstall slot %0d: got %0d expected %0d", d, alloc_rnid[d], exp2[d]);
      end
    end
    tick();
    n_checks++; if (free_count !== 6'd0) begin n_fail++;
      $display("FAIL empty_count: got %0d expected 0", free_count); end
    alloc_mask = 4'b0001;
    #1;
    n_checks++; if (alloc_ready !== 1'b0) begin n_fail++;
      $display("FAIL empty_ready1: got %0b expected 0", alloc_ready); end
    alloc_mask = 4'b0000;
    #1;
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++;
      $display("FAIL empty_ready0: got %0b expected 1", alloc_ready); end
    tick();
  endtask

  task automatic test_overflow();
    // Asynchronous reset mid-cycle restores a full list immediately.
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (free_count !== 6'd32) begin n_fail++;
      $display("FAIL async_reset_count: got %0d expected 32", free_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    upd.commit = 1'b1; upd.rnid_valid = 4'b0001;
    upd.old_rnid[0] = 6'd9; upd.rd_regidx[0] = 5'd1;
    tick();
    n_checks++; if (ovf !== 1'b1) begin n_fail++;
      $display("FAIL ovf_set: got %0b expected 1", ovf); end
    n_checks++; if (free_count !== 6'd32) begin n_fail++;
      $display("FAIL ovf_count: got %0d expected 32", free_count); end
    alloc_mask = 4'b0001;
    #1;
    n_checks++; if (alloc_rnid[0] !== 6'd32) begin n_fail++;
      $display("FAIL ovf_no_overwrite: got %0d expected 32", alloc_rnid[0]); end
    tick();
    n_checks++; if (ovf !== 1'b1) begin n_fail++;
      $display("FAIL ovf_sticky: got %0b expected 1", ovf); end
    rst_n = 1'b0;
    #2;
    n_checks++; if (ovf !== 1'b0 || free_count !== 6'd32) begin n_fail++;
      $display("FAIL ovf_reset: got ovf=%0b count=%0d expected 0,32", ovf, free_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_push();
    test_drain_wrap();
    test_stall();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
